// File: rtl/knight_pkg.sv
// Shared definitions for the knight sprite renderer: status codes,
// animation FSM states, sprite geometry and the per-status sheet tables.
package knight_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_WALK   = 4'd1,
      ST_JUMP   = 4'd2,
      ST_FALL   = 4'd3,
      ST_ATTACK = 4'd4
   } status_e;

   typedef enum logic [1:0] {
      A_LOOP    = 2'd0,
      A_ONESHOT = 2'd1,
      A_DEAD    = 2'd2
   } anim_state_e;

   localparam int SPR_W    = 30;
   localparam int SPR_H    = 62;
   localparam int SPR_SIZE = 1860;
   localparam int HALF_W   = 15;
   localparam int HALF_H   = 31;

   // Last frame of the attack sheet; the one-shot and dead states park here.
   localparam logic [2:0] ONESHOT_LAST = 3'd4;

   // Unknown status codes render as idle.
   function automatic status_e eff_status(input logic [3:0] s);
      return (s > 4'd4) ? ST_IDLE : status_e'(s);
   endfunction

   function automatic logic [2:0] frame_count(input status_e s);
      case (s)
         ST_WALK:   return 3'd6;
         ST_JUMP:   return 3'd2;
         ST_FALL:   return 3'd2;
         ST_ATTACK: return 3'd5;
         default:   return 3'd4;
      endcase
   endfunction

   function automatic logic [4:0] sheet_base(input status_e s);
      case (s)
         ST_WALK:   return 5'd4;
         ST_JUMP:   return 5'd10;
         ST_FALL:   return 5'd12;
         ST_ATTACK: return 5'd14;
         default:   return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/knight_anim_ctrl.sv
// Animation controller: frame divider plus LOOP/ONESHOT/DEAD sequencing.
// Optional hit-flash blanking is built when KNIGHT_HIT_FLASH_EN is defined.
module knight_anim_ctrl
   import knight_pkg::*;
#(
   parameter int ANIM_DIV = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [3:0] status,
   input  logic [3:0] life,
   output logic [2:0] anim_frame,
   output logic [4:0] sheet,
   output logic       flash_blank
);

   localparam logic [3:0] DIV_LAST = 4'(ANIM_DIV - 1);

   anim_state_e state_q, state_next;
   logic [3:0]  status_q;
   logic [3:0]  div_q, div_next;
   logic [2:0]  frame_q, frame_next;
   status_e     cur;

   assign cur        = eff_status(status);
   assign anim_frame = frame_q;
   // frame_q always belongs to status_q, so the sheet follows the registered status
   assign sheet      = (state_q == A_DEAD) ? sheet_base(ST_ATTACK)
                                           : sheet_base(eff_status(status_q));

   // State, frame, divider and last-seen status registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= A_LOOP;
         frame_q  <= '0;
         div_q    <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_next;
         frame_q  <= frame_next;
         div_q    <= div_next;
         status_q <= status;
      end
   end

   // Next-state: death is sticky, a status change restarts the sequence and
   // outranks a coincident tick, otherwise ticks step the divider and frame
   always_comb begin
      state_next = state_q;
      frame_next = frame_q;
      div_next   = div_q;
      if (state_q == A_DEAD) begin
         frame_next = ONESHOT_LAST;
         div_next   = '0;
      end else if (life == 4'd0) begin
         state_next = A_DEAD;
         frame_next = ONESHOT_LAST;
         div_next   = '0;
      end else begin
         state_next = (cur == ST_ATTACK) ? A_ONESHOT : A_LOOP;
         if (status != status_q) begin
            frame_next = '0;
            div_next   = '0;
         end else if (tick) begin
            if (div_q >= DIV_LAST) begin
               div_next = '0;
               if (state_q == A_ONESHOT)
                  frame_next = (frame_q >= ONESHOT_LAST) ? ONESHOT_LAST : frame_q + 3'd1;
               else
                  frame_next = (frame_q >= frame_count(cur) - 3'd1) ? 3'd0 : frame_q + 3'd1;
            end else begin
               div_next = div_q + 4'd1;
            end
         end
      end
   end

`ifdef KNIGHT_HIT_FLASH_EN
   logic [3:0] life_q;
   logic       flash_on;
   logic [4:0] flash_cnt;

   // Damage flash: 32 ticks after a life drop, blanking while count bit 2 is set
   always_ff @(posedge clk) begin
      if (reset) begin
         life_q    <= '0;
         flash_on  <= 1'b0;
         flash_cnt <= '0;
      end else begin
         life_q <= life;
         if (state_q != A_DEAD && life != 4'd0 && life < life_q) begin
            flash_on  <= 1'b1;
            flash_cnt <= '0;
         end else if (flash_on && tick) begin
            if (flash_cnt == 5'd31) flash_on <= 1'b0;
            flash_cnt <= flash_cnt + 5'd1;
         end
      end
   end

   assign flash_blank = flash_on & flash_cnt[2];
`else
   assign flash_blank = 1'b0;
`endif

endmodule

// File: rtl/knight_sprite_renderer.sv
// Knight sprite renderer: box hit test and ROM address (stage 1), then
// ROM data qualification (stage 2). Optional KNIGHT_HIT_FLASH_EN adds
// hit-flash blanking inside knight_anim_ctrl.
module knight_sprite_renderer
   import knight_pkg::*;
#(
   parameter int         ANIM_DIV        = 6,
   parameter logic [7:0] TRANSPARENT_IDX = 8'h00
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic [9:0]  PlayerX,
   input  logic [9:0]  PlayerY,
   input  logic [3:0]  Player_Status,
   input  logic [3:0]  Player_Life,
   input  logic        Inverse,
   output logic [15:0] sprite_addr,
   input  logic [7:0]  sprite_data,
   output logic        knight_on,
   output logic [7:0]  knight_pixel,
   output logic [2:0]  anim_frame
);

   logic        frame_clk_d;
   logic        tick;
   logic [10:0] dx, dy;
   logic        hit;
   logic [4:0]  col;
   logic [4:0]  sheet;
   logic [4:0]  frame_sel;
   logic [15:0] addr_next;
   logic        flash_blank;
   logic [2:1]  vld_pipe;
   logic [2:1]  hit_pipe;
   logic        draw;

   assign tick = frame_clk & ~frame_clk_d;

   knight_anim_ctrl #(.ANIM_DIV(ANIM_DIV)) u_anim (
      .clk         (Clk),
      .reset       (Reset),
      .tick        (tick),
      .status      (Player_Status),
      .life        (Player_Life),
      .anim_frame  (anim_frame),
      .sheet       (sheet),
      .flash_blank (flash_blank)
   );

   // Offsets into the 30x62 box as 11-bit two's complement; negative => bit 10 set
   assign dx        = {1'b0, DrawX} - ({1'b0, PlayerX} - 11'(HALF_W));
   assign dy        = {1'b0, DrawY} - ({1'b0, PlayerY} - 11'(HALF_H));
   assign hit       = !dx[10] && (dx[9:0] < 10'(SPR_W)) && !dy[10] && (dy[9:0] < 10'(SPR_H));
   assign col       = Inverse ? 5'(SPR_W - 1) - dx[4:0] : dx[4:0];
   assign frame_sel = sheet + {2'b00, anim_frame};
   assign addr_next = 16'(frame_sel) * 16'(SPR_SIZE) + 16'(dy[5:0]) * 16'(SPR_W) + 16'(col);

   // Frame-tick edge register
   always_ff @(posedge Clk) begin
      if (Reset) frame_clk_d <= 1'b0;
      else       frame_clk_d <= frame_clk;
   end

   // Stage 1 presents the ROM address, stage 2 lines hit up with returned ROM data
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sprite_addr <= '0;
         vld_pipe    <= '0;
         hit_pipe    <= '0;
      end else begin
         sprite_addr <= hit ? addr_next : 16'd0;
         vld_pipe[1] <= 1'b1;
         hit_pipe[1] <= hit;
         vld_pipe[2] <= vld_pipe[1];
         hit_pipe[2] <= hit_pipe[1] & vld_pipe[1];
      end
   end

   assign draw         = vld_pipe[2] & hit_pipe[2] & (sprite_data != TRANSPARENT_IDX) & ~flash_blank;
   assign knight_on    = draw;
   assign knight_pixel = draw ? sprite_data : 8'h00;

endmodule

// File: tb/tb_knight_sprite_renderer.sv
// Self-checking bench for knight_sprite_renderer with a registered ROM model
// and a spec-level reference for addresses, animation frames and flashing.
module tb_knight_sprite_renderer;

`ifdef KNIGHT_HIT_FLASH_EN
   localparam bit FLASH = 1'b1;
`else
   localparam bit FLASH = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_clk = 1'b0;
   logic [9:0]  DrawX = '0, DrawY = '0, PlayerX = '0, PlayerY = '0;
   logic [3:0]  Player_Status = '0, Player_Life = 4'd3;
   logic        Inverse = 1'b0;
   logic [15:0] sprite_addr;
   logic [7:0]  sprite_data = '0;
   logic        knight_on;
   logic [7:0]  knight_pixel;
   logic [2:0]  anim_frame;

   int vectors = 0;
   int miscompares = 0;
   bit rom_zero = 1'b0;

   always #5 Clk = ~Clk;

   knight_sprite_renderer dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
      .DrawX(DrawX), .DrawY(DrawY), .PlayerX(PlayerX), .PlayerY(PlayerY),
      .Player_Status(Player_Status), .Player_Life(Player_Life), .Inverse(Inverse),
      .sprite_addr(sprite_addr), .sprite_data(sprite_data),
      .knight_on(knight_on), .knight_pixel(knight_pixel), .anim_frame(anim_frame)
   );

   function automatic logic [7:0] rom(input logic [15:0] a);
      if (rom_zero || a[1:0] == 2'b00) return 8'h00;
      return 8'(a * 3 + 1);
   endfunction

   // one-cycle-latency sprite ROM
   always @(posedge Clk) sprite_data <= rom(sprite_addr);

   // expected {addr, knight_on, knight_pixel} for a pixel on a given sheet
   function automatic logic [24:0] ref_pix(input int x, input int y, input int sheet);
      int ox, oy, addr;
      logic [7:0] d;
      ox = x - (int'(PlayerX) - 15);
      oy = y - (int'(PlayerY) - 31);
      if (ox < 0 || ox >= 30 || oy < 0 || oy >= 62) return 25'd0;
      addr = sheet * 1860 + oy * 30 + (Inverse ? 29 - ox : ox);
      d = rom(16'(addr));
      return {16'(addr), d != 8'h00, d};
   endfunction

   task automatic probe(input int x, input int y, output logic [24:0] got);
      @(negedge Clk);
      DrawX = 10'(x);
      DrawY = 10'(y);
      @(posedge Clk); #1 got[24:9] = sprite_addr;
      @(posedge Clk); #1 got[8:0] = {knight_on, knight_pixel};
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         @(negedge Clk) frame_clk = 1'b1;
         @(negedge Clk) frame_clk = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [24:0] e;
      PlayerX = 320; PlayerY = 377; Player_Status = 0; Player_Life = 3; Inverse = 0;
      DrawX = 306; DrawY = 347;
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      vectors++;
      if ({sprite_addr, knight_on, knight_pixel, anim_frame} !== 28'd0) begin
         miscompares++;
         $display("FAIL reset_state got addr=%0d on=%0b pix=%0d frame=%0d want all 0",
                  sprite_addr, knight_on, knight_pixel, anim_frame);
      end
      e = ref_pix(306, 347, 0);
      Reset = 1'b0;
      @(posedge Clk); #1;
      vectors++;
      if ({sprite_addr, knight_on} !== {e[24:9], 1'b0}) begin
         miscompares++;
         $display("FAIL reset_release_c1 got addr=%0d on=%0b want addr=%0d on=0", sprite_addr, knight_on, e[24:9]);
      end
      @(posedge Clk); #1;
      vectors++;
      if ({knight_on, knight_pixel} !== e[8:0]) begin
         miscompares++;
         $display("FAIL reset_release_c2 got on=%0b pix=%0d want on=%0b pix=%0d", knight_on, knight_pixel, e[8], e[7:0]);
      end
      tick_n(7);
      @(negedge Clk) Reset = 1'b1;
      @(posedge Clk); #1;
      vectors++;
      if ({sprite_addr, knight_on, knight_pixel, anim_frame} !== 28'd0) begin
         miscompares++;
         $display("FAIL reset_midframe got addr=%0d on=%0b pix=%0d frame=%0d want all 0",
                  sprite_addr, knight_on, knight_pixel, anim_frame);
      end
      @(negedge Clk) Reset = 1'b0;
   endtask

   task automatic test_spec_points();
      int pts[10][3] = '{'{305,346,0}, '{305,346,1}, '{334,407,0}, '{334,407,1}, '{304,346,0},
                         '{335,346,0}, '{305,345,0}, '{305,408,0}, '{334,346,1}, '{320,377,0}};
      logic [24:0] got, e;
      PlayerX = 320; PlayerY = 377;
      for (int i = 0; i < 10; i++) begin
         Inverse = pts[i][2][0];
         probe(pts[i][0], pts[i][1], got);
         e = ref_pix(pts[i][0], pts[i][1], 0);
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL point(%0d,%0d,inv%0d) got addr=%0d on=%0b pix=%0d want addr=%0d on=%0b pix=%0d",
                     pts[i][0], pts[i][1], pts[i][2], got[24:9], got[8], got[7:0], e[24:9], e[8], e[7:0]);
         end
      end
   endtask

   task automatic test_random();
      logic [24:0] got, e;
      int x, y;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         PlayerX = 10'($urandom_range(40, 980));
         PlayerY = 10'($urandom_range(40, 980));
         Inverse = 1'($urandom);
         x = int'(PlayerX) + int'($urandom_range(0, 50)) - 25;
         y = int'(PlayerY) + int'($urandom_range(0, 80)) - 40;
         probe(x, y, got);
         e = ref_pix(x, y, 0);
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL random(%0d,%0d) got addr=%0d on=%0b pix=%0d want addr=%0d on=%0b pix=%0d",
                     x, y, got[24:9], got[8], got[7:0], e[24:9], e[8], e[7:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [24:0] exp_q[$];
      PlayerX = 500; PlayerY = 500;
      for (int i = 0; i <= 24; i++) begin
         @(negedge Clk);
         if (i < 24) begin
            DrawX = 10'(485 + $urandom_range(0, 32) - 1);
            DrawY = 10'(469 + $urandom_range(0, 64) - 1);
            Inverse = 1'($urandom);
            exp_q.push_back(ref_pix(int'(DrawX), int'(DrawY), 0));
         end
         @(posedge Clk); #1;
         if (i < 24) begin
            vectors++;
            if (sprite_addr !== exp_q[i][24:9]) begin
               miscompares++;
               $display("FAIL b2b_addr[%0d] got %0d want %0d", i, sprite_addr, exp_q[i][24:9]);
            end
         end
         if (i > 0) begin
            vectors++;
            if ({knight_on, knight_pixel} !== exp_q[i-1][8:0]) begin
               miscompares++;
               $display("FAIL b2b_pix[%0d] got on=%0b pix=%0d want on=%0b pix=%0d",
                        i - 1, knight_on, knight_pixel, exp_q[i-1][8], exp_q[i-1][7:0]);
            end
         end
      end
   endtask

   task automatic test_walk();
      logic [24:0] got, e;
      int f;
      PlayerX = 320; PlayerY = 377; Inverse = 0;
      @(negedge Clk) Player_Status = 4'd1;
      repeat (2) @(negedge Clk);
      vectors++;
      if (anim_frame !== 3'd0) begin
         miscompares++;
         $display("FAIL walk_start got frame=%0d want 0", anim_frame);
      end
      for (int k = 1; k <= 36; k++) begin
         tick_n(1);
         f = (k / 6) % 6;
         vectors++;
         if (anim_frame !== 3'(f)) begin
            miscompares++;
            $display("FAIL walk_tick%0d got frame=%0d want %0d", k, anim_frame, f);
         end
         if (k % 6 == 0) begin
            probe(308, 348, got);
            e = ref_pix(308, 348, 4 + f);
            vectors++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL walk_addr_tick%0d got addr=%0d want %0d", k, got[24:9], e[24:9]);
            end
         end
      end
   endtask

   task automatic test_attack();
      logic [24:0] got, e;
      int f;
      @(negedge Clk) Player_Status = 4'd4;
      repeat (2) @(negedge Clk);
      for (int k = 1; k <= 40; k++) begin
         tick_n(1);
         f = (k / 6 > 4) ? 4 : k / 6;
         vectors++;
         if (anim_frame !== 3'(f)) begin
            miscompares++;
            $display("FAIL attack_tick%0d got frame=%0d want %0d", k, anim_frame, f);
         end
      end
      probe(308, 348, got);
      e = ref_pix(308, 348, 18);
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("FAIL attack_addr got addr=%0d want %0d", got[24:9], e[24:9]);
      end
      // status change coinciding with a tick: frame and divider restart
      @(negedge Clk) begin frame_clk = 1'b1; Player_Status = 4'd0; end
      @(negedge Clk) frame_clk = 1'b0;
      vectors++;
      if (anim_frame !== 3'd0) begin
         miscompares++;
         $display("FAIL change_on_tick got frame=%0d want 0", anim_frame);
      end
      tick_n(5);
      vectors++;
      if (anim_frame !== 3'd0) begin
         miscompares++;
         $display("FAIL change_div_5 got frame=%0d want 0", anim_frame);
      end
      tick_n(1);
      vectors++;
      if (anim_frame !== 3'd1) begin
         miscompares++;
         $display("FAIL change_div_6 got frame=%0d want 1", anim_frame);
      end
   endtask

   task automatic test_dead();
      logic [24:0] got, e;
      @(negedge Clk) Player_Life = 4'd1;
      @(negedge Clk) Player_Life = 4'd0;
      repeat (2) @(negedge Clk);
      vectors++;
      if (anim_frame !== 3'd4) begin
         miscompares++;
         $display("FAIL dead_enter got frame=%0d want 4", anim_frame);
      end
      tick_n(12);
      probe(308, 348, got);
      e = ref_pix(308, 348, 18);
      vectors++;
      if ({anim_frame, got} !== {3'd4, e}) begin
         miscompares++;
         $display("FAIL dead_hold got frame=%0d addr=%0d want 4 addr=%0d", anim_frame, got[24:9], e[24:9]);
      end
      @(negedge Clk) begin Player_Life = 4'd2; Player_Status = 4'd1; end
      repeat (2) @(negedge Clk);
      tick_n(12);
      probe(308, 348, got);
      vectors++;
      if ({anim_frame, got} !== {3'd4, e}) begin
         miscompares++;
         $display("FAIL dead_sticky got frame=%0d addr=%0d want 4 addr=%0d", anim_frame, got[24:9], e[24:9]);
      end
      @(negedge Clk) Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      vectors++;
      if (anim_frame !== 3'd0) begin
         miscompares++;
         $display("FAIL dead_reset got frame=%0d want 0", anim_frame);
      end
      tick_n(6);
      vectors++;
      if (anim_frame !== 3'd1) begin
         miscompares++;
         $display("FAIL alive_after_reset got frame=%0d want 1", anim_frame);
      end
   endtask

   task automatic test_flash();
      logic [24:0] got, e;
      bit blank;
      @(negedge Clk) begin
         Reset = 1'b1; Player_Status = 4'd0; Player_Life = 4'd2; Inverse = 1'b0;
         PlayerX = 320; PlayerY = 377; DrawX = 308; DrawY = 348;
      end
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk) Player_Life = 4'd1;
      repeat (2) @(negedge Clk);
      for (int k = 1; k <= 40; k++) begin
         tick_n(1);
         repeat (2) @(negedge Clk);
         e = ref_pix(308, 348, (k / 6) % 4);
         blank = FLASH && (k < 32) && ((k % 8) >= 4);
         vectors++;
         if (knight_on !== (e[8] && !blank)) begin
            miscompares++;
            $display("FAIL flash_tick%0d got on=%0b want %0b", k, knight_on, e[8] && !blank);
         end
      end
      rom_zero = 1'b1;
      for (int i = 0; i < 3; i++) begin
         probe(306 + 9 * i, 347 + 20 * i, got);
         vectors++;
         if (got[8:0] !== 9'd0) begin
            miscompares++;
            $display("FAIL rom_zero[%0d] got on=%0b pix=%0d want on=0 pix=0", i, got[8], got[7:0]);
         end
      end
      rom_zero = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_spec_points();
      test_random();
      test_back_to_back();
      test_walk();
      test_attack();
      test_dead();
      test_flash();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
